// File: rtl/ibex_ex_seq.sv
// ---------------------------------------------------------------------------
// ibex_ex_seq
//
// ID-side sequencer for the execution block. It takes one instruction at a
// time from the decoder and runs the EX multi-cycle handshake from the
// initiator end. It drives the first-cycle flag and the multiplier/divider
// enables and selects. It owns the two 34-bit intermediate value registers
// that EX writes and reads back. It captures the EX result and offers it
// downstream through a valid/ready handshake. A per-instruction cycle budget
// aborts an operation that never completes and reports it with an error
// pulse.
//
// Parameters
//   TimeoutCycles  EXEC cycles without ex_valid_i before the operation is
//                  aborted with error_o (must be >= 1)
//   ImdResetVal    reset value of both intermediate value registers
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   issue_valid_i/_ready_o    decoder handshake
//   issue_type_i              00 ALU, 01 MUL, 10 DIV, 11 reserved (as ALU)
//   kill_i                    flush; aborts any operation in progress
//   alu_instr_first_cycle_o   first EXEC cycle of the current instruction
//   mult_en_o, div_en_o       dynamic enables (EXEC only)
//   mult_sel_o, div_sel_o     static selects for the latched type (EXEC only)
//   multdiv_ready_id_o        ID can take the multdiv result (EXEC only)
//   ex_valid_i, result_ex_i   EX completion and result
//   imd_val_we_i, imd_val_d_i intermediate register write port from EX
//   imd_val_q_o               intermediate register contents to EX
//   result_valid_o/_ready_i   downstream result handshake
//   result_o                  captured result
//   busy_o                    sequencer not idle
//   error_o                   one-cycle pulse after a timeout
//   stall_cnt_o               saturating count of EXEC cycles after the first
// ---------------------------------------------------------------------------
module ibex_ex_seq #(
  parameter int unsigned  TimeoutCycles = 64,
  parameter logic [33:0]  ImdResetVal   = 34'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [1:0]        issue_type_i,
  input  logic              kill_i,

  output logic              alu_instr_first_cycle_o,
  output logic              mult_en_o,
  output logic              div_en_o,
  output logic              mult_sel_o,
  output logic              div_sel_o,
  output logic              multdiv_ready_id_o,

  input  logic              ex_valid_i,
  input  logic [31:0]       result_ex_i,

  input  logic [1:0]        imd_val_we_i,
  input  logic [1:0][33:0]  imd_val_d_i,
  output logic [1:0][33:0]  imd_val_q_o,

  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [31:0]       result_o,

  output logic              busy_o,
  output logic              error_o,
  output logic [15:0]       stall_cnt_o
);

  // The timeout counter only ever counts up to TimeoutCycles.
  localparam int unsigned TcntW = $clog2(TimeoutCycles + 1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    TYPE_ALU = 2'b00,
    TYPE_MUL = 2'b01,
    TYPE_DIV = 2'b10,
    TYPE_RSV = 2'b11
  } type_e;

  state_e              state_q, state_d;
  logic [1:0]          type_q, type_d;
  logic [TcntW-1:0]    tcnt_q, tcnt_d;
  logic [15:0]         stall_q, stall_d;
  logic [31:0]         result_q, result_d;
  logic                error_q, error_d;
  logic [1:0][33:0]    imd_q;

  logic                is_mul_s;
  logic                is_div_s;

  // Type decode of the latched instruction; reserved decodes as neither.
  always_comb begin
    is_mul_s = (type_q == TYPE_MUL);
    is_div_s = (type_q == TYPE_DIV);
  end

  // Next-state logic and state-derived outputs.
  always_comb begin
    state_d                 = state_q;
    type_d                  = type_q;
    tcnt_d                  = tcnt_q;
    stall_d                 = stall_q;
    result_d                = result_q;
    error_d                 = 1'b0;

    issue_ready_o           = 1'b0;
    alu_instr_first_cycle_o = 1'b0;
    mult_en_o               = 1'b0;
    div_en_o                = 1'b0;
    mult_sel_o              = 1'b0;
    div_sel_o               = 1'b0;
    multdiv_ready_id_o      = 1'b0;
    result_valid_o          = 1'b0;

    case (state_q)
      IDLE: begin
        issue_ready_o = ~kill_i;
        if (issue_valid_i && !kill_i) begin
          type_d  = issue_type_i;
          tcnt_d  = {TcntW{1'b0}};
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end

      EXEC: begin
        mult_sel_o         = is_mul_s;
        div_sel_o          = is_div_s;
        mult_en_o          = is_mul_s;
        div_en_o           = is_div_s;
        multdiv_ready_id_o = 1'b1;
        // The counter is cleared on entry and bumped on every cycle that
        // stays in EXEC, so zero identifies the first cycle.
        alu_instr_first_cycle_o = (tcnt_q == {TcntW{1'b0}});

        if (kill_i) begin
          state_d = IDLE;
        end else if (ex_valid_i) begin
          // A completion on the last budgeted cycle still counts.
          result_d = result_ex_i;
          state_d  = DONE;
        end else begin
          tcnt_d = tcnt_q + {{(TcntW-1){1'b0}}, 1'b1};
          if (stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
          end else begin
            stall_d = stall_q;
          end
          if (tcnt_q == TcntLast) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = EXEC;
          end
        end
      end

      DONE: begin
        result_valid_o = 1'b1;
        // Accepting a new instruction while handing off the result avoids
        // an idle bubble between back-to-back operations.
        issue_ready_o  = result_ready_i & ~kill_i;
        if (kill_i) begin
          state_d = IDLE;
        end else if (result_ready_i) begin
          if (issue_valid_i) begin
            type_d  = issue_type_i;
            tcnt_d  = {TcntW{1'b0}};
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: latched type, counters, result and error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      type_q   <= 2'b00;
      tcnt_q   <= {TcntW{1'b0}};
      stall_q  <= 16'd0;
      result_q <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      type_q   <= type_d;
      tcnt_q   <= tcnt_d;
      stall_q  <= stall_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  // Intermediate value registers; EX may only write them while executing,
  // and they survive kill and completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      imd_q[0] <= ImdResetVal;
      imd_q[1] <= ImdResetVal;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((state_q == EXEC) && !kill_i && imd_val_we_i[i]) begin
          imd_q[i] <= imd_val_d_i[i];
        end else begin
          imd_q[i] <= imd_q[i];
        end
      end
    end
  end

  // Registered values straight to the ports.
  always_comb begin
    imd_val_q_o = imd_q;
    result_o    = result_q;
    busy_o      = (state_q != IDLE);
    error_o     = error_q;
    stall_cnt_o = stall_q;
  end

endmodule

// File: doc/ibex_ex_seq.md
Name: ibex_ex_seq

Overview:
- ID-side sequencer and intermediate-value register holder for the execution block; the initiator end of the EX multi-cycle handshake.
- Accepts one instruction at a time from the decoder and drives the EX enable/select/first-cycle controls.
- Owns the two 34-bit intermediate value registers that EX writes through imd_val_we/imd_val_d and reads back on imd_val_q.
- Captures the EX result on ex_valid and presents it downstream with a valid/ready handshake.

Parameters:
- TimeoutCycles, 64: maximum EXEC-state cycles before abort with error; must be >= 1.
- ImdResetVal, 34'h0: reset value of both intermediate value registers.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- issue_valid_i  in  1  decoder has an instruction
- issue_ready_o  out  1  sequencer accepts the instruction
- issue_type_i  in  2  00 ALU, 01 MUL, 10 DIV, 11 reserved (treated as ALU)
- kill_i  in  1  flush; aborts any operation in progress
- alu_instr_first_cycle_o  out  1  first EXEC cycle of the current instruction
- mult_en_o / div_en_o  out  1 each  dynamic enables to the multiplier/divider
- mult_sel_o / div_sel_o  out  1 each  static selects for the latched type
- multdiv_ready_id_o  out  1  ID can accept the multdiv result
- ex_valid_i  in  1  EX result valid
- result_ex_i  in  32  EX result
- imd_val_we_i  in  2  per-register write enables from EX
- imd_val_d_i  in  2x34  write data
- imd_val_q_o  out  2x34  register contents to EX
- result_valid_o  out  1  captured result available
- result_ready_i  in  1  downstream accepts the result
- result_o  out  32  captured result
- busy_o  out  1  state != IDLE
- error_o  out  1  one-cycle pulse on timeout
- stall_cnt_o  out  16  saturating count of EXEC cycles after the first

Behaviour:
- Reset (asynchronous, rst_i=1):
  - State = IDLE.
  - All outputs are 0 except issue_ready_o=1.
  - imd_val_q_o = ImdResetVal.
  - stall_cnt_o = 0, timeout counter = 0.
  - Asserting reset mid-operation takes effect immediately, with no completion.
- States: IDLE, EXEC, DONE.
- IDLE:
  - issue_ready_o = 1.
  - On issue_valid_i & ~kill_i: latch the type, clear the timeout counter, and go to EXEC.
- EXEC:
  - mult_sel_o / div_sel_o follow the latched type.
  - mult_en_o = (type==MUL); div_en_o = (type==DIV); multdiv_ready_id_o = 1.
  - alu_instr_first_cycle_o = 1 only in the first EXEC cycle.
  - On ex_valid_i: result_o <= result_ex_i, go to DONE.
  - Otherwise, increment the timeout counter and the stall counter (stall_cnt_o saturates at 16'hFFFF and never wraps).
  - If the counter reaches TimeoutCycles without ex_valid_i: pulse error_o for one cycle and go to IDLE.
  - ex_valid_i in the same cycle as the timeout: ex_valid_i wins, and there is no error.
- DONE:
  - result_valid_o = 1; result_o is held stable.
  - All enables, selects and multdiv_ready_id_o are 0.
  - On result_ready_i:
    - If issue_valid_i is also 1, go directly to EXEC with the new type (issue_ready_o = result_ready_i in DONE, so there is no bubble).
    - Otherwise go to IDLE.
- Latency:
  - Issue accepted at cycle T; first EXEC cycle is T+1.
  - A single-cycle op with ex_valid_i at T+1 gives result_valid_o at T+2.
- Intermediate value registers:
  - Written only in EXEC: imd_q[i] <= imd_val_d_i[i] when imd_val_we_i[i].
  - Writes outside EXEC are ignored.
  - A write in the same cycle as ex_valid_i still takes effect.
  - New values are visible on imd_val_q_o the next cycle.
  - The registers are not cleared by kill or by completion.
- kill_i:
  - Highest priority in every state.
  - Next state is IDLE; result_valid_o and all enables drop the next cycle.
  - No error pulse.
  - An issue presented in the same cycle as kill_i is not accepted (issue_ready_o forced to 0 while kill_i=1).
  - stall_cnt_o is not cleared.
- Reserved type 11: executes as ALU (no enables, no selects).

Test Plan:
- Single-cycle ALU:
  - Stimulus: issue type 00 at T; ex_valid_i=1 with result_ex_i=32'h0000_1234 at T+1.
  - Response: alu_instr_first_cycle_o high at T+1 only; result_valid_o=1, result_o=32'h1234 at T+2; stall_cnt_o unchanged.
- Multi-cycle MUL:
  - Stimulus: ex_valid_i asserted in the 3rd EXEC cycle; imd_val_we_i=2'b01 with d[0]=34'h3_0000_0001 in the 1st EXEC cycle.
  - Response: mult_en_o high for 3 cycles; imd_val_q_o[0]=34'h3_0000_0001 from the next cycle; imd_val_q_o[1] unchanged; stall_cnt_o +2.
- Back-to-back:
  - Stimulus: in DONE, result_ready_i=1 and issue_valid_i=1 with type 10.
  - Response: issue accepted; next cycle is EXEC with div_en_o=1 and alu_instr_first_cycle_o=1; no idle cycle.
- Kill:
  - Stimulus: kill_i in the 2nd EXEC cycle of a DIV.
  - Response: IDLE next cycle; div_en_o=0; result_valid_o never asserted.
  - Stimulus: kill_i together with issue_valid_i in IDLE.
  - Response: issue_ready_o=0 and the instruction is not accepted.
- Timeout:
  - Stimulus: TimeoutCycles=4 and ex_valid_i held at 0.
  - Response: error_o pulses exactly one cycle after the 4th EXEC cycle; then IDLE with issue_ready_o=1.
- Async reset:
  - Stimulus: rst_i asserted mid-EXEC, between clock edges.
  - Response: outputs immediately take reset values; imd_val_q_o=ImdResetVal; busy_o=0.
